// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: latch enables and bubble controls.
// Optional stall-cycle performance counter enabled by defining PIPE_STALL_CTRL_PERF_EN.
module pipe_stall_ctrl #(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned MD_TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] d_rs1,
  input  logic [REG_W-1:0] d_rs2,
  input  logic             d_uses_rs1,
  input  logic             d_uses_rs2,
  input  logic             x_is_load,
  input  logic [REG_W-1:0] x_rd,
  input  logic             x_is_md,
  input  logic             x_branch_taken,
  input  logic             md_ready,
  output logic             pc_en,
  output logic             fd_en,
  output logic             dx_en,
  output logic             xm_en,
  output logic             mw_en,
  output logic             fd_bubble,
  output logic             dx_bubble,
  output logic             xm_bubble,
  output logic             md_start,
  output logic             md_timeout,
  output logic [31:0]      stall_cycles
);

  typedef enum logic [0:0] {StRun, StMdWait} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic pc_en_c, fd_en_c, dx_en_c, xm_en_c, mw_en_c;
  logic fd_bubble_c, dx_bubble_c, xm_bubble_c, md_start_c, md_timeout_c;
  logic load_use;

  // A load to r0 never creates a hazard.
  assign load_use = x_is_load && (x_rd != '0) &&
                    ((d_uses_rs1 && (d_rs1 == x_rd)) || (d_uses_rs2 && (d_rs2 == x_rd)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_en_c      = 1'b1;
    fd_en_c      = 1'b1;
    dx_en_c      = 1'b1;
    xm_en_c      = 1'b1;
    mw_en_c      = 1'b1;
    fd_bubble_c  = 1'b0;
    dx_bubble_c  = 1'b0;
    xm_bubble_c  = 1'b0;
    md_start_c   = 1'b0;
    md_timeout_c = 1'b0;
    unique case (state_q)
      StRun: begin
        if (x_branch_taken) begin
          fd_bubble_c = 1'b1;
          dx_bubble_c = 1'b1;
        end else if (x_is_md) begin
          md_start_c  = 1'b1;
          pc_en_c     = 1'b0;
          fd_en_c     = 1'b0;
          dx_en_c     = 1'b0;
          xm_bubble_c = 1'b1;
          state_d     = StMdWait;
          cnt_d       = 8'd1;
        end else if (load_use) begin
          pc_en_c     = 1'b0;
          fd_en_c     = 1'b0;
          dx_bubble_c = 1'b1;
        end
      end
      StMdWait: begin
        if (md_ready) begin
          state_d = StRun;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'(MD_TIMEOUT)) begin
          md_timeout_c = 1'b1;
          state_d      = StRun;
          cnt_d        = 8'd0;
        end else begin
          pc_en_c     = 1'b0;
          fd_en_c     = 1'b0;
          dx_en_c     = 1'b0;
          xm_bubble_c = 1'b1;
          cnt_d       = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StRun;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low for as long as reset is asserted, not just at the edge.
  assign pc_en      = reset_n & pc_en_c;
  assign fd_en      = reset_n & fd_en_c;
  assign dx_en      = reset_n & dx_en_c;
  assign xm_en      = reset_n & xm_en_c;
  assign mw_en      = reset_n & mw_en_c;
  assign fd_bubble  = reset_n & fd_bubble_c;
  assign dx_bubble  = reset_n & dx_bubble_c;
  assign xm_bubble  = reset_n & xm_bubble_c;
  assign md_start   = reset_n & md_start_c;
  assign md_timeout = reset_n & md_timeout_c;

`ifdef PIPE_STALL_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_en && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: one default instance (MD_TIMEOUT=40), one with MD_TIMEOUT=4.
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] d_rs1 = '0, d_rs2 = '0, x_rd = '0;
  logic       d_uses_rs1 = 0, d_uses_rs2 = 0, x_is_load = 0, x_is_md = 0;
  logic       x_branch_taken = 0, md_ready = 0;

  logic pc_a, fd_a, dx_a, xm_a, mw_a, fdb_a, dxb_a, xmb_a, st_a, to_a;
  logic pc_b, fd_b, dx_b, xm_b, mw_b, fdb_b, dxb_b, xmb_b, st_b, to_b;
  logic [31:0] sc_a, sc_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.REG_W(5), .MD_TIMEOUT(40)) dut_a (
    .clk(clk), .reset_n(reset_n), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_uses_rs1(d_uses_rs1),
    .d_uses_rs2(d_uses_rs2), .x_is_load(x_is_load), .x_rd(x_rd), .x_is_md(x_is_md),
    .x_branch_taken(x_branch_taken), .md_ready(md_ready), .pc_en(pc_a), .fd_en(fd_a),
    .dx_en(dx_a), .xm_en(xm_a), .mw_en(mw_a), .fd_bubble(fdb_a), .dx_bubble(dxb_a),
    .xm_bubble(xmb_a), .md_start(st_a), .md_timeout(to_a), .stall_cycles(sc_a)
  );

  pipe_stall_ctrl #(.REG_W(5), .MD_TIMEOUT(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_uses_rs1(d_uses_rs1),
    .d_uses_rs2(d_uses_rs2), .x_is_load(x_is_load), .x_rd(x_rd), .x_is_md(x_is_md),
    .x_branch_taken(x_branch_taken), .md_ready(md_ready), .pc_en(pc_b), .fd_en(fd_b),
    .dx_en(dx_b), .xm_en(xm_b), .mw_en(mw_b), .fd_bubble(fdb_b), .dx_bubble(dxb_b),
    .xm_bubble(xmb_b), .md_start(st_b), .md_timeout(to_b), .stall_cycles(sc_b)
  );

  // {pc, fd, dx, xm, mw, fd_bubble, dx_bubble, xm_bubble, md_start, md_timeout}
  logic [9:0] out_a, out_b;
  assign out_a = {pc_a, fd_a, dx_a, xm_a, mw_a, fdb_a, dxb_a, xmb_a, st_a, to_a};
  assign out_b = {pc_b, fd_b, dx_b, xm_b, mw_b, fdb_b, dxb_b, xmb_b, st_b, to_b};

  localparam logic [9:0] OutIdle  = 10'b11111_000_00;
  localparam logic [9:0] OutLoadU = 10'b00111_010_00;
  localparam logic [9:0] OutBr    = 10'b11111_110_00;
  localparam logic [9:0] OutStart = 10'b00011_001_10;
  localparam logic [9:0] OutHold  = 10'b00011_001_00;
  localparam logic [9:0] OutTo    = 10'b11111_000_01;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, ld, md, br;
    logic [9:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    d_rs1 = '0; d_rs2 = '0; x_rd = '0; d_uses_rs1 = 0; d_uses_rs2 = 0;
    x_is_load = 0; x_is_md = 0; x_branch_taken = 0; md_ready = 0;
  endtask

  vec_t vecs[9];
  int   low, starts, tos;
  logic [31:0] sc_before;

  initial begin
    vecs[0] = '{"idle",          5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, OutIdle};
    vecs[1] = '{"loaduse_rs2",   5'd3, 5'd5, 5'd5, 0, 1, 1, 0, 0, OutLoadU};
    vecs[2] = '{"load_r0",       5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 0, OutIdle};
    vecs[3] = '{"loaduse_rs1",   5'd7, 5'd2, 5'd7, 1, 0, 1, 0, 0, OutLoadU};
    vecs[4] = '{"rs1_unused",    5'd7, 5'd2, 5'd7, 0, 1, 1, 0, 0, OutIdle};
    vecs[5] = '{"not_load",      5'd9, 5'd9, 5'd9, 1, 1, 0, 0, 0, OutIdle};
    vecs[6] = '{"branch_vs_lu",  5'd5, 5'd5, 5'd5, 1, 1, 1, 0, 1, OutBr};
    vecs[7] = '{"branch_vs_md",  5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, OutBr};
    vecs[8] = '{"rs2_unused",    5'd4, 5'd6, 5'd6, 1, 0, 1, 0, 0, OutIdle};

    // Reset state, before any clock edge.
    #3;
    chk("reset_out_a", 32'(out_a), 32'h0);
    chk("reset_out_b", 32'(out_b), 32'h0);
    chk("reset_stall_cycles", sc_a, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      d_rs1 = vecs[i].rs1; d_rs2 = vecs[i].rs2; x_rd = vecs[i].rd;
      d_uses_rs1 = vecs[i].u1; d_uses_rs2 = vecs[i].u2; x_is_load = vecs[i].ld;
      x_is_md = vecs[i].md; x_branch_taken = vecs[i].br;
      #1;
      chk(vecs[i].name, 32'(out_a), 32'(vecs[i].exp));
      tick();
    end
    clear_inputs();
    #1;
    chk("after_vectors_idle", 32'(out_a), 32'(OutIdle));

    // Mult/div with md_ready 17 cycles after md_start.
    sc_before = sc_a;
    low = 0; starts = 0;
    x_is_md = 1;
    for (int c = 0; c <= 17; c++) begin
      md_ready = (c == 17);
      #1;
      if (!pc_a) low++;
      if (st_a) starts++;
      chk($sformatf("md17_c%0d", c), 32'(out_a),
          32'((c == 0) ? OutStart : (c == 17) ? OutIdle : OutHold));
      tick();
    end
    clear_inputs();
    #1;
    chk("md17_pc_low_cycles", 32'(low), 32'd17);
    chk("md17_start_pulses", 32'(starts), 32'd1);
    chk("md17_back_to_run", 32'(out_a), 32'(OutIdle));
`ifdef PIPE_STALL_CTRL_PERF_EN
    chk("md17_stall_cycles", sc_a - sc_before, 32'd17);
`else
    chk("stall_cycles_tied_0", sc_a, 32'h0);
`endif

    // Timeout on the MD_TIMEOUT=4 instance.
    x_is_md = 1;
    for (int c = 0; c <= 4; c++) begin
      #1;
      chk($sformatf("to_c%0d", c), 32'(out_b),
          32'((c == 0) ? OutStart : (c == 4) ? OutTo : OutHold));
      tick();
    end
    x_is_md = 0;
    #1;
    chk("to_then_run", 32'(out_b), 32'(OutIdle));
    // Same again, md_ready coincides with the timeout cycle.
    x_is_md = 1;
    for (int c = 0; c <= 4; c++) begin
      md_ready = (c == 4);
      #1;
      chk($sformatf("to_rdy_c%0d", c), 32'(out_b),
          32'((c == 0) ? OutStart : (c == 4) ? OutIdle : OutHold));
      tick();
    end
    clear_inputs();

    // Reset mid-stall: both instances in MD_WAIT, then reset asynchronously.
    @(negedge clk);
    reset_n = 0; #1; reset_n = 1;
    tick();
    x_is_md = 1;
    tick();
    x_is_md = 0;
    #1;
    chk("pre_reset_hold", 32'(out_b), 32'(OutHold));
    #2;
    reset_n = 0;
    #1;
    chk("mid_reset_out_a", 32'(out_a), 32'h0);
    chk("mid_reset_out_b", 32'(out_b), 32'h0);
    chk("mid_reset_stall", sc_a, 32'h0);
    tick();
    @(negedge clk);
    reset_n = 1;
    #1;
    chk("post_reset_a", 32'(out_a), 32'(OutIdle));
    chk("post_reset_b", 32'(out_b), 32'(OutIdle));
    tos = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (to_a || to_b || !pc_b) tos++;
    end
    chk("post_reset_no_timeout", 32'(tos), 32'd0);

`ifdef PIPE_STALL_CTRL_PERF_EN
    // Saturation: preload the counter near max and hold a stall.
    @(negedge clk);
    force dut_a.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut_a.stall_cycles_q;
    x_is_md = 1;
    for (int c = 0; c < 4; c++) tick();
    chk("perf_saturate", sc_a, 32'hFFFF_FFFF);
    clear_inputs();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
